// File: rtl/parking_spot_allocator_pkg.sv
// Shared constants for the parking spot allocator: lot size, FSM encoding and
// the occupancy bit convention used by the bitmap vectors.
package parking_spot_allocator_pkg;

  localparam int NUM_SPOTS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_GRANT  = 2'd2,
    ST_REJECT = 2'd3
  } state_e;

  // A set bit in the occupancy bitmap marks a taken spot.
  localparam logic SPOT_OCCUPIED = 1'b1;

endpackage

// File: rtl/parking_spot_allocator_popcount.sv
// Combinational free-spot counter: number of spots not marked occupied.
module spot_popcount
  import parking_spot_allocator_pkg::*;
#(
  parameter int NUM_SPOTS = NUM_SPOTS_DEF,
  parameter int CNT_W     = $clog2(NUM_SPOTS + 1)
) (
  input  logic [NUM_SPOTS-1:0] bitmap_i,
  output logic [CNT_W-1:0]     free_cnt_o
);

  logic [CNT_W-1:0] cnt_s;

  // Accumulate one per spot that is free.
  always_comb begin
    cnt_s = '0;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      cnt_s = cnt_s + CNT_W'(bitmap_i[i] != SPOT_OCCUPIED);
    end
  end

  assign free_cnt_o = cnt_s;

endmodule

// File: rtl/parking_spot_allocator.sv
// Sequential first-free-spot allocator: snapshots the occupancy bitmap on an
// entry request and scans it one spot per cycle, granting or rejecting.
module parking_spot_allocator
  import parking_spot_allocator_pkg::*;
#(
  parameter int NUM_SPOTS = NUM_SPOTS_DEF,
  parameter int IDX_W     = $clog2(NUM_SPOTS),
  parameter int CNT_W     = $clog2(NUM_SPOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enter_req,
  input  logic [NUM_SPOTS-1:0] parking_capacity,
  output logic [NUM_SPOTS-1:0] park_location,
  output logic                 grant,
  output logic                 reject,
  output logic                 busy,
  output logic [CNT_W-1:0]     free_count
);

  state_e               state_q;
  logic [NUM_SPOTS-1:0] snap_q;
  logic [NUM_SPOTS-1:0] loc_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic                 grant_q;
  logic                 reject_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     free_q;
  logic [CNT_W-1:0]     free_cnt_s;
  logic [NUM_SPOTS-1:0] onehot_s;
  logic                 full_s;

  spot_popcount #(
    .NUM_SPOTS (NUM_SPOTS),
    .CNT_W     (CNT_W)
  ) u_popcount (
    .bitmap_i   (parking_capacity),
    .free_cnt_o (free_cnt_s)
  );

  // Scan-step helpers: next index, one-hot of current index, full-lot flag.
  always_comb begin
    idx_d           = idx_q + IDX_W'(1);
    onehot_s        = '0;
    onehot_s[idx_q] = 1'b1;
    full_s          = &parking_capacity;
  end

  // Allocation FSM with registered outputs, index counter and snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      snap_q   <= '0;
      loc_q    <= '0;
      idx_q    <= '0;
      grant_q  <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      free_q   <= '0;
    end else begin
      case (state_q)
        // The grant cycle doubles as an idle edge so a held request is
        // re-accepted immediately, keeping back-to-back spacing at k+2.
        ST_IDLE, ST_GRANT: begin
          grant_q  <= 1'b0;
          reject_q <= 1'b0;
          if (enter_req) begin
            snap_q  <= parking_capacity;
            free_q  <= free_cnt_s;
            idx_q   <= '0;
            loc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= full_s ? ST_REJECT : ST_SCAN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (snap_q[idx_q] != SPOT_OCCUPIED) begin
            loc_q   <= onehot_s;
            grant_q <= 1'b1;
            state_q <= ST_GRANT;
          end else begin
            idx_q   <= idx_d;
          end
        end
        ST_REJECT: begin
          reject_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          grant_q  <= 1'b0;
          reject_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign park_location = loc_q;
  assign grant         = grant_q;
  assign reject        = reject_q;
  assign busy          = busy_q;
  assign free_count    = free_q;

endmodule

// File: doc/parking_spot_allocator.md
Name: parking_spot_allocator

Overview:
- Sits directly upstream of calculate_new_capacity.
- On a car-entry request it snapshots the current occupancy bitmap and scans it sequentially, one spot per cycle, from spot 0 upward.
- It returns the first free spot as a one-hot park_location, which calculate_new_capacity merges into the bitmap.
- A full lot is rejected with a one-cycle pulse.

Parameters:
- NUM_SPOTS, 8, number of parking spots; width of all bitmap/location vectors.
- IDX_W, 3, scan index width, equal to clog2(NUM_SPOTS).
- CNT_W, 4, free-count width, equal to clog2(NUM_SPOTS+1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enter_req  input  1  car-entry request; sampled only in IDLE.
- parking_capacity  input  NUM_SPOTS  occupancy bitmap, bit i = 1 means spot i occupied.
- park_location  output  NUM_SPOTS  one-hot allocated spot; all-zero when none.
- grant  output  1  one-cycle pulse: park_location is valid.
- reject  output  1  one-cycle pulse: lot full, no spot allocated.
- busy  output  1  high whenever state is not IDLE.
- free_count  output  CNT_W  number of zero bits in the snapshot taken at acceptance.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; park_location=0, grant=0, reject=0, busy=0, free_count=0, snapshot=0, idx=0. Takes effect immediately, including mid-scan; no grant or reject is emitted for an aborted request.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SCAN, GRANT, REJECT.
- IDLE:
  - enter_req=0: stay in IDLE.
  - enter_req=1 at edge E0 (acceptance): snapshot<=parking_capacity; free_count<=popcount(parking_capacity inverted); idx<=0; park_location<=0.
  - Next state is REJECT if parking_capacity is all ones, otherwise SCAN.
- SCAN, each edge:
  - If snapshot[idx]==0: park_location<=one-hot(idx); next state GRANT.
  - Else: idx<=idx+1; stay in SCAN.
  - idx never wraps, because a free bit is guaranteed after a non-full check.
- GRANT: grant=1 for exactly one cycle; next state IDLE.
- REJECT: reject=1 for exactly one cycle; park_location stays 0; next state IDLE.
- Latency: for first free index k, GRANT is entered at edge E(k+1), and grant is high between E(k+1) and E(k+2). Reject is high between E1 and E2.
- Output hold: park_location holds its last grant value until the next acceptance clears it. free_count holds until the next acceptance.
- Snapshot rule: parking_capacity changes after E0 are ignored for that request.
- Request rule: enter_req is ignored while busy=1. A level held high is re-accepted on the first IDLE edge after GRANT/REJECT, so back-to-back requests are spaced at least k+2 cycles.
- grant and reject are never high in the same cycle. park_location never has more than one bit set.

Decomposition:
- Shared package:
  - NUM_SPOTS default constant.
  - State encoding constants: IDLE=2'd0, SCAN=2'd1, GRANT=2'd2, REJECT=2'd3.
  - Occupancy convention (1 = occupied).
- One natural sub-module: spot_popcount, a combinational NUM_SPOTS-bit zero counter producing free_count.
- The FSM, index counter and snapshot register stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with enter_req=1 -> park_location=8'h00, grant=0, reject=0, busy=0, free_count=0 throughout.
- Spot 0 free: parking_capacity=8'b10100000, pulse enter_req -> grant high E1–E2; park_location=8'b00000001; free_count=6; busy high E0–E2.
- Spot 3 free: parking_capacity=8'b00000111 -> grant high E4–E5; park_location=8'b00001000; free_count=5; no grant before E4.
- Full: parking_capacity=8'hFF -> reject high E1–E2; grant never high; park_location=8'h00; free_count=0.
- Snapshot and busy ignore: parking_capacity=8'b00001111 at E0, then changed to 8'h00 at E1 while enter_req stays high -> grant at E5 with park_location=8'b00010000. Next acceptance occurs at E6 with snapshot 8'h00, giving grant at E7 with park_location=8'b00000001.
- Reset mid-scan: parking_capacity=8'b01111111, drop rst_n at E3 -> outputs clear immediately; no grant after rst_n release with enter_req=0.
